// File: rtl/nn_mac_engine_if.sv
// Handshake, weight-load and result bundle for nn_mac_engine.
// master: feature/sequencing side driving requests; slave: the engine.
interface nn_mac_engine_if #(
  parameter int N_IN  = 6,
  parameter int N_HID = 7,
  parameter int N_OUT = 3,
  parameter int W_W   = 12,
  parameter int ACC_W = 28,
  parameter int LVL_W = 4
);
  localparam int DEPTH = N_HID*(N_IN+1) + N_OUT*(N_HID+1);
  localparam int AW    = $clog2(DEPTH);
  localparam int MW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                     start;
  logic [N_IN-1:0]          in_vec;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [W_W-1:0]           wr_data;
  logic                     busy;
  logic                     done;
  logic [MW-1:0]            move;
  logic [N_OUT*ACC_W-1:0]   scores;
  logic [N_HID*LVL_W-1:0]   hid_level;
  logic [N_OUT*LVL_W-1:0]   out_level;

  modport master (
    output start, in_vec, wr_en, wr_addr, wr_data,
    input  busy, done, move, scores, hid_level, out_level
  );

  modport slave (
    input  start, in_vec, wr_en, wr_addr, wr_data,
    output busy, done, move, scores, hid_level, out_level
  );
endinterface

// File: rtl/nn_mac_engine.sv
// Two-layer ReLU classifier evaluated on one time-shared MAC unit.
// Weights live in a flat register file walked sequentially: hidden rows
// (inputs then bias) followed by output rows (hidden then bias), so a single
// incrementing pointer addresses every weight in the order it is consumed.
//
// state | meaning
// IDLE  | waiting for start, weight writes allowed
// HID   | hidden layer: N_IN MAC cycles + 1 bias/ReLU cycle per node
// OUT   | output layer: N_HID MAC cycles + 1 bias/clamp cycle per class
// ARG   | one compare per class; last cycle publishes all results
module nn_mac_engine #(
  parameter int N_IN    = 6,
  parameter int N_HID   = 7,
  parameter int N_OUT   = 3,
  parameter int W_W     = 12,
  parameter int H_W     = 12,
  parameter int ACC_W   = 28,
  parameter int HID_DIV = 60,
  parameter int OUT_DIV = 240,
  parameter int LVL_MAX = 12,
  parameter int LVL_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  nn_mac_engine_if.slave   bus
);

  localparam int OB    = N_HID*(N_IN+1);
  localparam int DEPTH = OB + N_OUT*(N_HID+1);
  localparam int AW    = $clog2(DEPTH);
  localparam int MW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int MAXA  = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int MAXN  = (MAXA > N_OUT) ? MAXA : N_OUT;
  localparam int CNT_W = $clog2(MAXN+1);

  localparam logic [CNT_W-1:0] N_IN_C     = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] N_HID_C    = CNT_W'(N_HID);
  localparam logic [CNT_W-1:0] N_HID_M1   = CNT_W'(N_HID-1);
  localparam logic [CNT_W-1:0] N_OUT_M1   = CNT_W'(N_OUT-1);
  localparam logic [AW-1:0]    DEPTH_C    = AW'(DEPTH);
  localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'((1 << H_W) - 1);
  localparam logic [H_W-1:0]   HDIV_C     = H_W'(HID_DIV);
  localparam logic [H_W-1:0]   HLVL_C     = H_W'(LVL_MAX);
  localparam logic [ACC_W-1:0] ODIV_C     = ACC_W'(OUT_DIV);
  localparam logic [ACC_W-1:0] OLVL_C     = ACC_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_C      = LVL_W'(LVL_MAX);

  typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_ARG} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         term_q, node_q;
  logic [AW-1:0]            ptr_q;
  logic [N_IN-1:0]          in_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [W_W-1:0]           w_mem [DEPTH];
  logic [H_W-1:0]           hidden_q [N_HID];
  logic signed [ACC_W-1:0]  score_buf [N_OUT];
  logic signed [ACC_W-1:0]  best_q;
  logic [MW-1:0]            best_idx_q;
  logic                     done_q;
  logic [MW-1:0]            move_q;
  logic [N_OUT*ACC_W-1:0]   scores_q;
  logic [N_HID*LVL_W-1:0]   hid_lvl_q, hid_lvl_d;
  logic [N_OUT*LVL_W-1:0]   out_lvl_q, out_lvl_d;

  logic [W_W-1:0]           w_rd;
  logic [H_W-1:0]           hid_sel;
  logic signed [ACC_W-1:0]  w_ext, hid_ext, prod, bias_sum;
  logic                     better;
  logic [H_W-1:0]           hq;
  logic [ACC_W-1:0]         sq;

  function automatic logic [H_W-1:0] relu_sat(input logic signed [ACC_W-1:0] v);
    if (v < 0)          return '0;
    else if (v > H_MAX) return '1;
    else                return v[H_W-1:0];
  endfunction

  // MAC operand selection and arithmetic for the current cycle
  always_comb begin
    w_rd     = w_mem[ptr_q];
    w_ext    = {{(ACC_W-W_W){w_rd[W_W-1]}}, w_rd};
    hid_sel  = (term_q < N_HID_C) ? hidden_q[term_q] : '0;
    hid_ext  = {{(ACC_W-H_W){1'b0}}, hid_sel};
    prod     = hid_ext * w_ext;
    bias_sum = acc_q + w_ext;
    better   = (term_q == '0) || (score_buf[term_q] > best_q);
  end

  // display levels derived from the finished hidden values and scores
  always_comb begin
    hid_lvl_d = '0;
    out_lvl_d = '0;
    hq        = '0;
    sq        = '0;
    for (int h = 0; h < N_HID; h++) begin
      hq = hidden_q[h] / HDIV_C;
      hid_lvl_d[h*LVL_W +: LVL_W] = (hq > HLVL_C) ? LVL_C : hq[LVL_W-1:0];
    end
    for (int o = 0; o < N_OUT; o++) begin
      sq = $unsigned(score_buf[o]) / ODIV_C;
      out_lvl_d[o*LVL_W +: LVL_W] = (sq > OLVL_C) ? LVL_C : sq[LVL_W-1:0];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state decode from the phase counters
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_HID;
      S_HID:  if (term_q == N_IN_C  && node_q == N_HID_M1) state_d = S_OUT;
      S_OUT:  if (term_q == N_HID_C && node_q == N_OUT_M1) state_d = S_ARG;
      S_ARG:  if (term_q == N_OUT_M1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // weight register file; writes only land while the engine is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) w_mem[i] <= '0;
    end else if (state_q == S_IDLE && bus.wr_en && bus.wr_addr < DEPTH_C) begin
      w_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // datapath: counters, accumulator, layer results and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q     <= '0;
      node_q     <= '0;
      ptr_q      <= '0;
      in_q       <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
      move_q     <= '0;
      scores_q   <= '0;
      hid_lvl_q  <= '0;
      out_lvl_q  <= '0;
      for (int h = 0; h < N_HID; h++) hidden_q[h]  <= '0;
      for (int o = 0; o < N_OUT; o++) score_buf[o] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            in_q   <= bus.in_vec;
            term_q <= '0;
            node_q <= '0;
            ptr_q  <= '0;
            acc_q  <= '0;
          end
        end
        S_HID: begin
          ptr_q <= ptr_q + 1'b1;
          if (term_q == N_IN_C) begin
            hidden_q[node_q] <= relu_sat(bias_sum);
            acc_q  <= '0;
            term_q <= '0;
            node_q <= (node_q == N_HID_M1) ? '0 : node_q + 1'b1;
          end else begin
            if (in_q[term_q]) acc_q <= acc_q + w_ext;
            term_q <= term_q + 1'b1;
          end
        end
        S_OUT: begin
          ptr_q <= ptr_q + 1'b1;
          if (term_q == N_HID_C) begin
            score_buf[node_q] <= (bias_sum < 0) ? '0 : bias_sum;
            acc_q  <= '0;
            term_q <= '0;
            node_q <= (node_q == N_OUT_M1) ? '0 : node_q + 1'b1;
          end else begin
            acc_q  <= acc_q + prod;
            term_q <= term_q + 1'b1;
          end
        end
        S_ARG: begin
          term_q <= term_q + 1'b1;
          if (better) begin
            best_q     <= score_buf[term_q];
            best_idx_q <= term_q[MW-1:0];
          end
          if (term_q == N_OUT_M1) begin
            done_q    <= 1'b1;
            move_q    <= better ? term_q[MW-1:0] : best_idx_q;
            hid_lvl_q <= hid_lvl_d;
            out_lvl_q <= out_lvl_d;
            for (int o = 0; o < N_OUT; o++) scores_q[o*ACC_W +: ACC_W] <= score_buf[o];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.move      = move_q;
  assign bus.scores    = scores_q;
  assign bus.hid_level = hid_lvl_q;
  assign bus.out_level = out_lvl_q;

endmodule

// File: doc/nn_mac_engine.md
Name: nn_mac_engine

Overview:
- Sequential, parametrised successor to the combinational fixed-weight classifier used by the game-move logic.
- Evaluates a two-layer ReLU network with a single time-shared multiply-accumulate unit. Weights are runtime-loadable, and sizes are generic.
- Takes a binary feature vector on a start handshake and returns per-class scores, the argmax move and saturated display levels for hidden and output nodes.
- Sits between the sensor/feature logic and the move/display logic.

Parameters:
N_IN, 6, number of binary inputs
N_HID, 7, number of hidden nodes
N_OUT, 3, number of output classes (>=2)
W_W, 12, signed weight/bias width (two's complement)
H_W, 12, unsigned hidden activation width
ACC_W, 28, signed accumulator/score width; must be >= H_W+W_W+clog2(N_HID+1)
HID_DIV, 60, divisor for hidden display level
OUT_DIV, 240, divisor for output display level
LVL_MAX, 12, display level ceiling
LVL_W, 4, display level width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request inference; sampled in IDLE only
in_vec  in  N_IN  binary features, captured on accepted start
wr_en  in  1  weight write strobe
wr_addr  in  clog2(DEPTH)  weight address, DEPTH = N_HID*(N_IN+1)+N_OUT*(N_HID+1)
wr_data  in  W_W  signed weight/bias value
busy  out  1  high while inference runs
done  out  1  one-cycle pulse when results are updated
move  out  clog2(N_OUT)  argmax class index
scores  out  N_OUT*ACC_W  clamped class scores, class 0 in LSBs
hid_level  out  N_HID*LVL_W  per-hidden-node display level, node 0 in LSBs
out_level  out  N_OUT*LVL_W  per-class display level

Behaviour:

Reset:
- rst_n low clears every weight register, all hidden registers, scores, move, hid_level, out_level, busy and done to 0.
- The FSM goes to IDLE.
- This applies at any time, including mid-inference. An inference aborted by reset never pulses done.

Weight map:
- Hidden weight (h,i) is at address h*(N_IN+1)+i. The hidden bias is at i=N_IN.
- Output weight (o,h) is at address OB+o*(N_HID+1)+h, with OB = N_HID*(N_IN+1). The output bias is at h=N_HID.
- A write takes effect at the clock edge.
- Writes are ignored while busy=1.
- Writes with wr_addr >= DEPTH are ignored.

FSM states: IDLE -> HID -> OUT -> ARG -> IDLE.
- IDLE:
  - start=1 captures in_vec, sets busy and goes to HID.
  - start while busy is ignored.
- HID:
  - For each h, run N_IN cycles of acc += in_vec[i] ? w(h,i) : 0, then one bias cycle.
  - The bias cycle writes hidden[h] = ReLU(acc+bias), saturated to 2^H_W-1.
  - The bias cycle also clears acc for the next node.
  - Phase length: N_HID*(N_IN+1) cycles.
- OUT:
  - For each o, run N_HID cycles of acc += hidden[h]*w(o,h), with an unsigned-by-signed product, then one bias cycle.
  - The bias cycle stores score[o] = max(acc+bias, 0) into an internal buffer.
  - Phase length: N_OUT*(N_HID+1) cycles.
- ARG:
  - One comparison per class over N_OUT cycles, using strict greater-than, so the lowest index wins ties.
  - On the last cycle, drop busy and pulse done.
  - In the same cycle, update scores, move, out_level and hid_level together.
  - Return to IDLE.

Latency and output holding:
- Start accepted at edge k; done is high in the cycle after edge k+L, with L = N_HID*(N_IN+1)+N_OUT*(N_HID+1)+N_OUT. The default is L=76.
- Outputs hold their previous values until that done.
- A new start is accepted in the cycle after done.

Levels:
- hid_level[h] = min(hidden[h]/HID_DIV, LVL_MAX).
- out_level[o] = min(score[o]/OUT_DIV, LVL_MAX).
- Both use integer truncating division.

Arithmetic:
- Weights and biases are sign-extended to ACC_W.
- The ACC_W constraint guarantees no accumulator overflow. Sizes violating it are unsupported.

Test Plan:
1. Reset with rst_n low, then release, with no start -> busy=0, done=0, move=0, scores=0, all levels 0. Start with all-zero weights and in_vec=6'b101010 -> done after 76 cycles, scores=0, move=0 (tie, lowest index).
2. Write 100 to addr 0 (w(0,0)) and 3 to addr 57 (w(1,0)); start with in_vec=6'b000001 -> hidden0=100, hid_level0=1, scores={0,300,0}, out_level1=1, move=1. done occurs exactly at k+76.
3. Write 2047 to addrs 0..5 and start with in_vec=6'b111111 -> hidden0 saturates to 4095, hid_level0=12. Additionally write -100 (12'hF9C) to addr 7 (w(1,0)) -> hidden1=0, hid_level1=0.
4. Write bias 5 to addr 72 (output bias of class 2) and -7 to addr 64 (output bias of class 1) -> scores={0,0,5}, move=2, class 1 clamped to 0.
5. Issue start and a wr_en to addr 72 during cycles 10..20 of a run -> no restart, done still at k+76, and addr 72 is unchanged on the next run.
6. Assert rst_n low at cycle 30 of a run -> busy=0 immediately, done never pulses, and all weights and outputs read 0. A subsequent start completes normally.
